// File: rtl/cycle_block_counter_if.sv
// Output bundle of the block counter: per-clock position index and end-of-block marker.
// The width of count is derived from cpc here, so producer and consumers always agree on it.
interface cycle_block_counter_if #(
  parameter int cpc = 4
);
  localparam int CW = (cpc > 1) ? $clog2(cpc) : 1;

  logic          cycle_clk;
  logic [CW-1:0] count;

  modport master (output cycle_clk, output count);
  modport slave  (input  cycle_clk, input  count);
endinterface

// File: rtl/cycle_block_counter.sv
// Free-running modulo-cpc counter that splits the clock into blocks of cpc cycles.
// It flags the last cycle of every block with a one-clock-wide cycle_clk pulse.
module cycle_block_counter #(
  parameter int cpc = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cycle_block_counter_if.master bus
);
  localparam int            CW   = (cpc > 1) ? $clog2(cpc) : 1;
  localparam logic [CW-1:0] LAST = CW'(cpc - 1);

  // Power-up values equal the reset preload, so the first run edge always starts at position 0.
  logic [CW-1:0] count_r     = LAST;
  logic          cycle_clk_r = 1'b1;
  logic [CW-1:0] count_next;

  // Wrap is decided before the increment, so count never reaches cpc or aliases at 2^CW.
  always_comb begin
    count_next = count_r + CW'(1);
    if (count_r == LAST) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= LAST;
      cycle_clk_r <= 1'b1;
    end else begin
      count_r     <= count_next;
      cycle_clk_r <= (count_next == LAST);
    end
  end

  assign bus.count     = count_r;
  assign bus.cycle_clk = cycle_clk_r;
endmodule

// File: tb/tb_cycle_block_counter.sv
// Scoreboard bench for cycle_block_counter, run side by side at cpc = 6, 4 and 1.
// The model counts run edges since the last reset and derives every position from that count.
module tb_cycle_block_counter;
  localparam int NCFG = 3;

  typedef struct {
    int count6;
    int count4;
    int count1;
    int cc6;
    int cc4;
    int cc1;
  } expect_t;

  logic clk;
  logic reset;

  int checks   = 0;
  int failures = 0;

  expect_t sb[$];
  int      runs[NCFG];
  int      cpcs[NCFG] = '{6, 4, 1};

  cycle_block_counter_if #(.cpc(6)) bus6 ();
  cycle_block_counter_if #(.cpc(4)) bus4 ();
  cycle_block_counter_if #(.cpc(1)) bus1 ();

  cycle_block_counter #(.cpc(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
  cycle_block_counter #(.cpc(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  cycle_block_counter #(.cpc(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Rising edges at 10, 20, 30 ns, ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives reset for the coming edge and queues what every configuration must show after it.
  task automatic apply_stimulus(input bit rst);
    expect_t e;
    int      exp_count[NCFG];
    reset = rst;
    for (int i = 0; i < NCFG; i++) begin
      if (rst) begin
        runs[i]      = 0;
        exp_count[i] = cpcs[i] - 1;
      end else begin
        runs[i]++;
        exp_count[i] = (runs[i] - 1) % cpcs[i];
      end
    end
    e.count6 = exp_count[0];
    e.count4 = exp_count[1];
    e.count1 = exp_count[2];
    e.cc6    = (exp_count[0] == cpcs[0] - 1) ? 1 : 0;
    e.cc4    = (exp_count[1] == cpcs[1] - 1) ? 1 : 0;
    e.cc1    = (exp_count[2] == cpcs[2] - 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  // Monitor: the counter presents a new output on every edge, so one entry is popped per edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_underflow: got output with no queued expectation at %0t", $time);
      end else begin
        e = sb.pop_front();
        check_output("count_cpc6",     int'(bus6.count),     e.count6);
        check_output("cycle_clk_cpc6", int'(bus6.cycle_clk), e.cc6);
        check_output("count_cpc4",     int'(bus4.count),     e.count4);
        check_output("cycle_clk_cpc4", int'(bus4.cycle_clk), e.cc4);
        check_output("count_cpc1",     int'(bus1.count),     e.count1);
        check_output("cycle_clk_cpc1", int'(bus1.cycle_clk), e.cc1);
      end
    end
  end

  initial begin
    int burst;
    for (int i = 0; i < NCFG; i++) runs[i] = 0;
    reset = 1'b1;
    #5;
    check_output("powerup_count_cpc6",     int'(bus6.count),     5);
    check_output("powerup_cycle_clk_cpc6", int'(bus6.cycle_clk), 1);
    check_output("powerup_count_cpc4",     int'(bus4.count),     3);
    check_output("powerup_cycle_clk_cpc4", int'(bus4.cycle_clk), 1);
    check_output("powerup_count_cpc1",     int'(bus1.count),     0);
    check_output("powerup_cycle_clk_cpc1", int'(bus1.cycle_clk), 1);

    // Reset over edges 10..40, release before edge 50.
    apply_stimulus(1'b1);
    repeat (3) begin
      @(negedge clk);
      apply_stimulus(1'b1);
    end
    // Fifteen run edges leave cpc=6 at position 2, then reset lands mid-block for one clock.
    repeat (15) begin
      @(negedge clk);
      apply_stimulus(1'b0);
    end
    @(negedge clk);
    apply_stimulus(1'b1);
    repeat (30) begin
      @(negedge clk);
      apply_stimulus(1'b0);
    end

    // Random phase: mostly running, with occasional reset bursts of 1..4 clocks.
    burst = 0;
    repeat (400) begin
      @(negedge clk);
      if (burst == 0 && $urandom_range(0, 11) == 0) begin
        burst = $urandom_range(1, 4);
      end
      if (burst > 0) begin
        burst--;
        apply_stimulus(1'b1);
      end else begin
        apply_stimulus(1'b0);
      end
    end

    @(posedge clk);
    #2;
    check_output("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
